// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU and load writeback.
// Optional conflict statistics counter enabled by defining RF_WB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic          CLK,
  input  logic          nRst,
  input  logic          i_src0_valid,
  input  logic [AW-1:0] i_src0_sel,
  input  logic [DW-1:0] i_src0_dat,
  output logic          o_src0_ready,
  input  logic          i_src1_valid,
  input  logic [AW-1:0] i_src1_sel,
  input  logic [DW-1:0] i_src1_dat,
  output logic          o_src1_ready,
  output logic          o_wen,
  output logic [AW-1:0] o_wsel,
  output logic [DW-1:0] o_wdat,
  output logic          o_busy,
  output logic [15:0]   o_conflict_cnt
);
  typedef enum logic {EMPTY, FULL} buf_t;
  buf_t r_st0, r_st1, w_st0_nxt, w_st1_nxt;
  logic [AW-1:0] r_sel0, r_sel1, r_wsel, w_gsel;
  logic [DW-1:0] r_dat0, r_dat1, r_wdat, w_gdat;
  logic r_rr, r_wen, w_full0, w_full1, w_gnt0, w_gnt1, w_ld0, w_ld1, w_wr;
  // r_rr=0 prefers src0; grant depends only on buffer state, never on valid
  always_comb begin
    w_full0 = r_st0 == FULL;
    w_full1 = r_st1 == FULL;
    w_gnt0 = w_full0 && (!w_full1 || !r_rr);
    w_gnt1 = w_full1 && (!w_full0 || r_rr);
    o_src0_ready = !w_full0 || w_gnt0;
    o_src1_ready = !w_full1 || w_gnt1;
    w_ld0 = i_src0_valid && o_src0_ready;
    w_ld1 = i_src1_valid && o_src1_ready;
    w_st0_nxt = w_ld0 ? FULL : (w_gnt0 ? EMPTY : r_st0);
    w_st1_nxt = w_ld1 ? FULL : (w_gnt1 ? EMPTY : r_st1);
    w_gsel = w_gnt1 ? r_sel1 : r_sel0;
    w_gdat = w_gnt1 ? r_dat1 : r_dat0;
    w_wr = (w_gnt0 || w_gnt1) && !(DROP_ZERO && w_gsel == '0);
  end
  always_ff @(posedge CLK or negedge nRst)
    if (!nRst) begin
      r_st0 <= EMPTY;
      r_st1 <= EMPTY;
      r_sel0 <= '0;
      r_sel1 <= '0;
      r_dat0 <= '0;
      r_dat1 <= '0;
      r_rr <= 1'b0;
      r_wen <= 1'b0;
      r_wsel <= '0;
      r_wdat <= '0;
    end else begin
      r_st0 <= w_st0_nxt;
      r_st1 <= w_st1_nxt;
      if (w_ld0) begin
        r_sel0 <= i_src0_sel;
        r_dat0 <= i_src0_dat;
      end
      if (w_ld1) begin
        r_sel1 <= i_src1_sel;
        r_dat1 <= i_src1_dat;
      end
      if (w_full0 && w_full1) r_rr <= ~r_rr;
      r_wen <= w_wr;
      // dropped r0 writes leave the previous wsel/wdat on the port
      if (w_wr) begin
        r_wsel <= w_gsel;
        r_wdat <= w_gdat;
      end
    end
  assign o_wen = r_wen;
  assign o_wsel = r_wsel;
  assign o_wdat = r_wdat;
  assign o_busy = w_full0 || w_full1 || r_wen;
`ifdef RF_WB_STATS_EN
  logic [15:0] r_cnt;
  always_ff @(posedge CLK or negedge nRst)
    if (!nRst) r_cnt <= '0;
    else if (w_full0 && w_full1 && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign o_conflict_cnt = r_cnt;
`else
  assign o_conflict_cnt = 16'h0000;
`endif
endmodule
